fft_peak_finder: RTL and testbench
==================================

# fft_peak_finder

Streaming peak detector placed directly downstream of the FFT magnitude stage. It consumes one frame of per-bin power values (|re|²+|im|²) and tracks the largest bin inside a configurable search window. At end of frame it reports that bin's index and magnitude, with a qualifying flag, to the pitch/note stage. It drives the ready that backpressures the FFT source.

## Interface
Parameters:
- MIN_BIN, 2: lowest bin searched; excludes DC and near-DC.
- MAX_BIN, 511: highest bin searched; the upper half of a 1024-point real FFT is a mirror.
- THRESH, 64'd4096: minimum peak power for a valid detection.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mag_valid  in  1  the current beat carries a bin magnitude.
- mag_sop  in  1  first bin of a frame; qualified by mag_valid.
- mag_eop  in  1  last bin of a frame; qualified by mag_valid.
- mag  in  64  unsigned bin power.
- in_ready  out  1  block can accept a beat; drives the FFT source_ready.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the downstream stage accepts the result.
- peak_bin  out  11  index of the maximum bin.
- peak_mag  out  64  power of the maximum bin.
- peak_found  out  1  set when peak_mag >= THRESH.

## Operation
- A beat is accepted only when mag_valid && in_ready.
- FSM states: IDLE, SCAN, REPORT.
- IDLE:
  - in_ready=1.
  - An accepted beat without sop is discarded.
  - An accepted sop beat loads the internal bin counter to 1 and processes bin 0. The state moves to SCAN, or to REPORT if eop is also set (single-beat frame).
- SCAN:
  - in_ready=1.
  - Each accepted beat is bin number bin_cnt; bin_cnt then increments, saturating at 2047.
  - Bins outside [MIN_BIN, MAX_BIN] are counted but not compared.
  - In-window bin: if mag > best_mag (strict, unsigned), set best_mag=mag and best_bin=bin_cnt. On a tie the earlier bin wins.
  - Accepted eop moves to REPORT; that beat is still evaluated first.
  - Accepted sop while in SCAN: abandon the current frame, clear best, and restart at bin 0 with the new beat. No result is emitted for the abandoned frame.
- Frame start: best_mag=0 and best_bin=0. A frame with no in-window bins reports bin 0, mag 0, found 0.
- REPORT:
  - in_ready=0.
  - out_valid=1, with peak_bin, peak_mag and peak_found registered and held stable.
  - When out_valid && out_ready, return to IDLE and drop out_valid.
- peak_found = (best_mag >= THRESH), computed as the state enters REPORT.
- Reset values (asynchronous): state IDLE, in_ready 0 while reset_n is low and 1 on the first cycle after release, out_valid 0, peak_bin 0, peak_mag 0, peak_found 0, best and counter 0.
- Reset mid-frame or mid-REPORT aborts with no partial result.

## Timing
- The compare/update of a beat accepted at edge t is visible in best at t+1.
- eop accepted at edge t gives out_valid=1 and final outputs from t+1. Latency is 1 cycle.
- in_ready falls in the same cycle out_valid rises. in_ready and out_valid are registered state decodes with no combinational path from input to output.
- out_ready high at the eop+1 edge means a 1-cycle REPORT; IDLE is reached at t+2. The next sop is accepted no earlier than t+2.
- Outputs must not change while out_valid=1 && out_ready=0.
- Sustained throughput: 1 beat/cycle within a frame, plus a 1-cycle minimum gap between frames.

## Structure
- Shared package tuner_pkg holds:
  - MAG_W=64 and BIN_W=11.
  - The state enum {IDLE, SCAN, REPORT}.
  - A result typedef struct {bin, mag, found} reused by the note-mapping stage.
- A single module is sufficient. The comparator is one inline 64-bit unsigned compare; no sub-module is needed.

## Test plan
- Frame of 512 beats with mag=10 except bin 100=5000 -> out_valid one cycle after eop, peak_bin=100, peak_mag=5000, peak_found=1.
- Bins 50 and 80 both 9000 -> peak_bin=50 (tie keeps first). Bin 1=1e9 with MIN_BIN=2 -> ignored.
- All bins 100 -> peak_bin=MIN_BIN=2, peak_mag=100, peak_found=0.
- out_ready held low for 20 cycles after eop -> outputs stable and in_ready=0 throughout. Accepted on cycle 21, then IDLE.
- sop reasserted at bin 300 of a frame whose peak was bin 200=8000, new frame peak bin 40=7000 -> single result with peak_bin=40, peak_mag=7000.
- reset_n pulsed low at bin 250 -> all outputs 0 immediately. The following full frame reports correctly and no result is emitted for the aborted frame.

Source files
------------

// File: rtl/tuner_pkg.sv
// Shared types for the tuner pipeline: widths, peak-finder FSM states and
// the result record handed to the note-mapping stage.
package tuner_pkg;

  localparam int MAG_W = 64;
  localparam int BIN_W = 11;

  // Highest representable bin index; the bin counter saturates here.
  localparam logic [BIN_W-1:0] BIN_LAST = 11'd2047;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_e;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [MAG_W-1:0] mag;
    logic             found;
  } result_t;

  // Next bin index, holding at the last index instead of wrapping to 0.
  function automatic logic [BIN_W-1:0] bin_inc_sat(input logic [BIN_W-1:0] b);
    return (b == BIN_LAST) ? b : (b + 11'd1);
  endfunction

endpackage

// File: rtl/fft_peak_finder.sv
// Streaming peak detector behind the FFT magnitude stage. Tracks the
// strongest bin in [MIN_BIN, MAX_BIN] over one frame and presents it with a
// threshold flag on a valid/ready result port once the frame ends.
module fft_peak_finder
  import tuner_pkg::*;
#(
  parameter int unsigned MIN_BIN = 2,
  parameter int unsigned MAX_BIN = 511,
  parameter logic [63:0] THRESH  = 64'd4096
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             mag_valid,
  input  logic             mag_sop,
  input  logic             mag_eop,
  input  logic [MAG_W-1:0] mag,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] peak_bin,
  output logic [MAG_W-1:0] peak_mag,
  output logic             peak_found
);

  localparam logic [BIN_W-1:0] MIN_B = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_BIN);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [BIN_W-1:0] best_bin_q, best_bin_d;
  logic [MAG_W-1:0] best_mag_q, best_mag_d;
  result_t          peak_q, peak_d;

  logic             accept_s;
  logic             start_s;
  logic             eval_s;
  logic             in_win_s;
  logic [BIN_W-1:0] cur_bin_s;
  logic [BIN_W-1:0] base_bin_s;
  logic [MAG_W-1:0] base_mag_s;

  // A sop beat restarts the frame from bin 0 in IDLE as well as mid-SCAN.
  assign accept_s   = mag_valid && in_ready_q;
  assign start_s    = accept_s && mag_sop;
  assign eval_s     = start_s || (accept_s && (state_q == SCAN));
  assign cur_bin_s  = start_s ? {BIN_W{1'b0}} : bin_cnt_q;
  assign base_bin_s = start_s ? {BIN_W{1'b0}} : best_bin_q;
  assign base_mag_s = start_s ? {MAG_W{1'b0}} : best_mag_q;
  assign in_win_s   = (cur_bin_s >= MIN_B) && (cur_bin_s <= MAX_B);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: frame start, frame end, result handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = mag_eop ? REPORT : SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (accept_s && mag_eop) begin
          state_d = REPORT;
        end else begin
          state_d = SCAN;
        end
      end
      REPORT: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = REPORT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state.
  always_comb begin
    in_ready_d  = (state_d != REPORT);
    out_valid_d = (state_d == REPORT);
  end

  // Per-beat compare: strict greater-than so the earliest of equal bins wins.
  always_comb begin
    bin_cnt_d  = bin_cnt_q;
    best_bin_d = best_bin_q;
    best_mag_d = best_mag_q;
    if (eval_s) begin
      bin_cnt_d  = bin_inc_sat(cur_bin_s);
      best_bin_d = base_bin_s;
      best_mag_d = base_mag_s;
      if (in_win_s && (mag > base_mag_s)) begin
        best_bin_d = cur_bin_s;
        best_mag_d = mag;
      end else begin
        best_bin_d = base_bin_s;
        best_mag_d = base_mag_s;
      end
    end else begin
      bin_cnt_d  = bin_cnt_q;
    end
  end

  // Capture the final result (including the eop beat) on entry to REPORT.
  always_comb begin
    peak_d = peak_q;
    if ((state_d == REPORT) && (state_q != REPORT)) begin
      peak_d.bin   = best_bin_d;
      peak_d.mag   = best_mag_d;
      peak_d.found = (best_mag_d >= THRESH);
    end else begin
      peak_d = peak_q;
    end
  end

  // Datapath and handshake registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      bin_cnt_q   <= {BIN_W{1'b0}};
      best_bin_q  <= {BIN_W{1'b0}};
      best_mag_q  <= {MAG_W{1'b0}};
      peak_q      <= '{bin: {BIN_W{1'b0}}, mag: {MAG_W{1'b0}}, found: 1'b0};
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bin_cnt_q   <= bin_cnt_d;
      best_bin_q  <= best_bin_d;
      best_mag_q  <= best_mag_d;
      peak_q      <= peak_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign peak_bin   = peak_q.bin;
  assign peak_mag   = peak_q.mag;
  assign peak_found = peak_q.found;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Self-checking bench for fft_peak_finder. Inputs change and outputs are
// sampled on the falling clock edge; expected results come from a frame-level
// reference that scans the stored frame for the first maximum in the window.
module tb_fft_peak_finder;

  localparam int          MINB = 2;
  localparam int          MAXB = 511;
  localparam logic [63:0] TH   = 64'd4096;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        mag_valid = 1'b0;
  logic        mag_sop   = 1'b0;
  logic        mag_eop   = 1'b0;
  logic [63:0] mag       = 64'd0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [10:0] peak_bin;
  logic [63:0] peak_mag;
  logic        peak_found;

  int n_tests = 0;
  int n_fail  = 0;
  int result_events = 0;
  logic ov_prev = 1'b0;
  logic [63:0] frame_mag [0:2047];

  fft_peak_finder #(.MIN_BIN(MINB), .MAX_BIN(MAXB), .THRESH(TH)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .mag_valid (mag_valid),
    .mag_sop   (mag_sop),
    .mag_eop   (mag_eop),
    .mag       (mag),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag),
    .peak_found(peak_found)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Count each rising out_valid as one emitted result.
  always @(negedge CLOCK_50) begin
    if (out_valid === 1'b1 && ov_prev !== 1'b1) result_events <= result_events + 1;
    ov_prev <= out_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: first strictly-largest bin among in-window bins actually sent.
  function automatic void ref_peak(input int n, output logic [10:0] b,
                                   output logic [63:0] m, output logic f);
    b = 11'd0;
    m = 64'd0;
    for (int i = MINB; i <= MAXB && i < n; i++) begin
      if (frame_mag[i] > m) begin
        m = frame_mag[i];
        b = 11'(i);
      end
    end
    f = (m >= TH);
  endfunction

  function automatic logic [63:0] rand_mag();
    case ($urandom_range(0, 4))
      0: return {$urandom, $urandom};
      1: return TH;
      2: return TH - 64'd1;
      3: return 64'($urandom_range(0, 100));
      default: return 64'($urandom_range(0, 8000));
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic drive_beat(input logic sop, input logic eop, input logic [63:0] m);
    int guard;
    mag_valid = 1'b1; mag_sop = sop; mag_eop = eop; mag = m;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge CLOCK_50);
      guard++;
    end
    if (guard >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL drive_beat: in_ready=%b after 50 cycles, required 1", in_ready);
    end
    @(negedge CLOCK_50);
  endtask

  task automatic run_frame(input int n, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        mag_valid = 1'b0;
        @(negedge CLOCK_50);
      end
      drive_beat(i == 0, i == n - 1, frame_mag[i]);
    end
    mag_valid = 1'b0; mag_sop = 1'b0; mag_eop = 1'b0;
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({in_ready, out_valid, peak_bin, peak_mag, peak_found} !== 78'd0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b vld=%b bin=%0d mag=%0d fnd=%b, required all 0",
               in_ready, out_valid, peak_bin, peak_mag, peak_found);
    end
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b vld=%b, required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_peak();
    logic [10:0] eb; logic [63:0] em; logic ef; int ev0;
    for (int i = 0; i < 512; i++) frame_mag[i] = 64'd10;
    frame_mag[100] = 64'd5000;
    ev0 = result_events;
    run_frame(512, 1'b0);
    ref_peak(512, eb, em, ef);
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: vld=%b rdy=%b one cycle after eop, required vld=1 rdy=0", out_valid, in_ready);
    end
    n_tests++;
    if ({peak_bin, peak_mag, peak_found} !== {eb, em, ef}) begin
      n_fail++;
      $display("FAIL single_result: got bin=%0d mag=%0d fnd=%b, required bin=%0d mag=%0d fnd=%b",
               peak_bin, peak_mag, peak_found, eb, em, ef);
    end
    accept_result();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_events - ev0 != 1) begin
      n_fail++;
      $display("FAIL single_handshake: vld=%b rdy=%b results=%0d, required vld=0 rdy=1 results=1",
               out_valid, in_ready, result_events - ev0);
    end
  endtask

  task automatic test_tie_and_low_bin();
    logic [10:0] eb; logic [63:0] em; logic ef;
    for (int i = 0; i < 512; i++) frame_mag[i] = 64'($urandom_range(0, 8999));
    frame_mag[50] = 64'd9000;
    frame_mag[80] = 64'd9000;
    frame_mag[1]  = 64'd1_000_000_000;
    run_frame(512, 1'b1);
    ref_peak(512, eb, em, ef);
    n_tests++;
    if (out_valid !== 1'b1 || {peak_bin, peak_mag, peak_found} !== {eb, em, ef}) begin
      n_fail++;
      $display("FAIL tie_lowbin: got vld=%b bin=%0d mag=%0d fnd=%b, required vld=1 bin=%0d mag=%0d fnd=%b",
               out_valid, peak_bin, peak_mag, peak_found, eb, em, ef);
    end
    accept_result();
  endtask

  task automatic test_flat();
    logic [10:0] eb; logic [63:0] em; logic ef;
    for (int i = 0; i < 512; i++) frame_mag[i] = 64'd100;
    run_frame(512, 1'b0);
    ref_peak(512, eb, em, ef);
    n_tests++;
    if (out_valid !== 1'b1 || {peak_bin, peak_mag, peak_found} !== {eb, em, ef}) begin
      n_fail++;
      $display("FAIL flat: got vld=%b bin=%0d mag=%0d fnd=%b, required vld=1 bin=%0d mag=%0d fnd=%b",
               out_valid, peak_bin, peak_mag, peak_found, eb, em, ef);
    end
    accept_result();
  endtask

  task automatic test_threshold();
    logic [10:0] eb; logic [63:0] em; logic ef;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20; i++) frame_mag[i] = 64'd0;
      frame_mag[5] = (k == 0) ? TH : TH - 64'd1;
      run_frame(20, 1'b0);
      ref_peak(20, eb, em, ef);
      n_tests++;
      if (out_valid !== 1'b1 || {peak_bin, peak_mag, peak_found} !== {eb, em, ef}) begin
        n_fail++;
        $display("FAIL threshold_%0d: got vld=%b bin=%0d mag=%0d fnd=%b, required vld=1 bin=%0d mag=%0d fnd=%b",
                 k, out_valid, peak_bin, peak_mag, peak_found, eb, em, ef);
      end
      accept_result();
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] eb; logic [63:0] em; logic ef; int ev0;
    for (int i = 0; i < 300; i++) frame_mag[i] = rand_mag();
    ev0 = result_events;
    run_frame(300, 1'b0);
    ref_peak(300, eb, em, ef);
    // A sop+eop beat offered during REPORT must be ignored.
    mag_valid = 1'b1; mag_sop = 1'b1; mag_eop = 1'b1; mag = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 20; c++) begin
      n_tests++;
      if ({out_valid, in_ready, peak_bin, peak_mag, peak_found} !== {1'b1, 1'b0, eb, em, ef}) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: got vld=%b rdy=%b bin=%0d mag=%0d fnd=%b, required vld=1 rdy=0 bin=%0d mag=%0d fnd=%b",
                 c, out_valid, in_ready, peak_bin, peak_mag, peak_found, eb, em, ef);
      end
      @(negedge CLOCK_50);
    end
    mag_valid = 1'b0; mag_sop = 1'b0; mag_eop = 1'b0;
    accept_result();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_events - ev0 != 1) begin
      n_fail++;
      $display("FAIL hold_release: vld=%b rdy=%b results=%0d, required vld=0 rdy=1 results=1",
               out_valid, in_ready, result_events - ev0);
    end
  endtask

  task automatic test_sop_restart();
    logic [10:0] eb; logic [63:0] em; logic ef; int ev0;
    ev0 = result_events;
    for (int i = 0; i < 300; i++)
      drive_beat(i == 0, 1'b0, (i == 200) ? 64'd8000 : 64'($urandom_range(0, 4000)));
    for (int i = 0; i < 512; i++) frame_mag[i] = 64'($urandom_range(0, 6999));
    frame_mag[40] = 64'd7000;
    run_frame(512, 1'b0);
    ref_peak(512, eb, em, ef);
    n_tests++;
    if (out_valid !== 1'b1 || {peak_bin, peak_mag, peak_found} !== {eb, em, ef}) begin
      n_fail++;
      $display("FAIL sop_restart: got vld=%b bin=%0d mag=%0d fnd=%b, required vld=1 bin=%0d mag=%0d fnd=%b",
               out_valid, peak_bin, peak_mag, peak_found, eb, em, ef);
    end
    accept_result();
    n_tests++;
    if (result_events - ev0 != 1) begin
      n_fail++;
      $display("FAIL sop_restart_count: results=%0d, required 1", result_events - ev0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] eb; logic [63:0] em; logic ef; int ev0;
    for (int i = 0; i < 250; i++) drive_beat(i == 0, 1'b0, 64'd50_000 + 64'(i));
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, peak_bin, peak_mag, peak_found} !== 78'd0) begin
      n_fail++;
      $display("FAIL midframe_reset: got rdy=%b vld=%b bin=%0d mag=%0d fnd=%b, required all 0",
               in_ready, out_valid, peak_bin, peak_mag, peak_found);
    end
    mag_valid = 1'b0; mag_sop = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    ev0 = result_events;
    for (int i = 0; i < 512; i++) frame_mag[i] = rand_mag();
    run_frame(512, 1'b0);
    ref_peak(512, eb, em, ef);
    n_tests++;
    if (out_valid !== 1'b1 || {peak_bin, peak_mag, peak_found} !== {eb, em, ef}) begin
      n_fail++;
      $display("FAIL after_reset: got vld=%b bin=%0d mag=%0d fnd=%b, required vld=1 bin=%0d mag=%0d fnd=%b",
               out_valid, peak_bin, peak_mag, peak_found, eb, em, ef);
    end
    accept_result();
    n_tests++;
    if (result_events - ev0 != 1) begin
      n_fail++;
      $display("FAIL after_reset_count: results=%0d, required 1", result_events - ev0);
    end
  endtask

  task automatic test_random_frames();
    int lens [8] = '{1, 2, 3, 512, 600, 0, 0, 0};
    logic [10:0] eb; logic [63:0] em; logic ef;
    for (int f = 0; f < 8; f++) begin
      int n;
      n = (lens[f] != 0) ? lens[f] : int'($urandom_range(4, 700));
      for (int i = 0; i < n; i++) frame_mag[i] = rand_mag();
      run_frame(n, 1'b1);
      ref_peak(n, eb, em, ef);
      n_tests++;
      if (out_valid !== 1'b1 || {peak_bin, peak_mag, peak_found} !== {eb, em, ef}) begin
        n_fail++;
        $display("FAIL random_%0d (len %0d): got vld=%b bin=%0d mag=%0d fnd=%b, required vld=1 bin=%0d mag=%0d fnd=%b",
                 f, n, out_valid, peak_bin, peak_mag, peak_found, eb, em, ef);
      end
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
      accept_result();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] eb; logic [63:0] em; logic ef; time t0;
    for (int i = 0; i < 30; i++) frame_mag[i] = rand_mag();
    run_frame(30, 1'b0);
    ref_peak(30, eb, em, ef);
    n_tests++;
    if (out_valid !== 1'b1 || {peak_bin, peak_mag, peak_found} !== {eb, em, ef}) begin
      n_fail++;
      $display("FAIL b2b_first: got vld=%b bin=%0d mag=%0d fnd=%b, required vld=1 bin=%0d mag=%0d fnd=%b",
               out_valid, peak_bin, peak_mag, peak_found, eb, em, ef);
    end
    accept_result();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
    end
    for (int i = 0; i < 40; i++) frame_mag[i] = rand_mag();
    t0 = $time;
    run_frame(40, 1'b0);
    ref_peak(40, eb, em, ef);
    n_tests++;
    if (($time - t0) != 40 * 20) begin
      n_fail++;
      $display("FAIL b2b_throughput: frame took %0t, required %0d", $time - t0, 40 * 20);
    end
    n_tests++;
    if (out_valid !== 1'b1 || {peak_bin, peak_mag, peak_found} !== {eb, em, ef}) begin
      n_fail++;
      $display("FAIL b2b_second: got vld=%b bin=%0d mag=%0d fnd=%b, required vld=1 bin=%0d mag=%0d fnd=%b",
               out_valid, peak_bin, peak_mag, peak_found, eb, em, ef);
    end
    accept_result();
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_tie_and_low_bin();
    test_flat();
    test_threshold();
    test_backpressure();
    test_sop_restart();
    test_reset_midframe();
    test_random_frames();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
